// File: rtl/vend_coin_arbiter_if.sv
// Coin-side, dispenser-side and status signals of the vending coin arbiter.
// master = coin acceptors / dispenser / hopper side, slave = the arbiter.
interface vend_coin_arbiter_if #(
  parameter int NUM_SLOTS = 2,
  parameter int CREDIT_W  = 4
);
  logic [NUM_SLOTS-1:0]   coin_valid;
  logic [2*NUM_SLOTS-1:0] coin_value;
  logic [NUM_SLOTS-1:0]   coin_ready;
  logic                   dispense_valid;
  logic                   dispense_ready;
  logic                   change_pulse;
  logic [CREDIT_W-1:0]    credit;
  logic                   busy;

  modport master (
    output coin_valid, coin_value, dispense_ready,
    input  coin_ready, dispense_valid, change_pulse, credit, busy
  );

  modport slave (
    input  coin_valid, coin_value, dispense_ready,
    output coin_ready, dispense_valid, change_pulse, credit, busy
  );
endinterface

// File: rtl/vend_coin_arbiter.sv
// Round-robin coin arbiter, credit accumulator, dispense handshake, change return; VEND_TIMEOUT_EN adds idle refund.
// Latency: price-completing coin -> dispense_valid next cycle; change pulses start the cycle after the handshake.
// Backpressure: dispense_valid held until dispense_ready; coin_ready is 0 whenever not in COLLECT.
module vend_coin_arbiter #(
  parameter int NUM_SLOTS      = 2,
  parameter int PRICE          = 4,
  parameter int CREDIT_W       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  vend_coin_arbiter_if.slave  bus
);

  localparam int                PTR_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W:0]    SLOTS_W = NUM_SLOTS[PTR_W:0];
  localparam logic [CREDIT_W:0] PRICE_W = PRICE[CREDIT_W:0];
  localparam logic [CREDIT_W-1:0] PRICE_C = PRICE[CREDIT_W-1:0];

  if (NUM_SLOTS < 1 || NUM_SLOTS > 8 || PRICE < 1 || PRICE > (1 << CREDIT_W) - 4 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("vend_coin_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                dispense_valid_q;
  logic                change_pulse_q;
  logic                busy_q;

`ifdef VEND_TIMEOUT_EN
  localparam int           TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  logic                gnt_found;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W:0]      cand;
  logic [PTR_W:0]      nxt_sum;
  logic [1:0]          gnt_val;
  logic                accept;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_sub;

  // Descending scan so the smallest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= SLOTS_W) cand = cand - SLOTS_W;
      if (bus.coin_valid[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end

    nxt_sum = {1'b0, gnt_idx} + (PTR_W+1)'(1);
    if (nxt_sum >= SLOTS_W) nxt_sum = '0;

    gnt_val = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (PTR_W'(i) == gnt_idx) gnt_val = bus.coin_value[2*i +: 2];
    end

    accept     = (state_q == COLLECT) && gnt_found;
    credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(gnt_val);
    credit_sub = credit_sum[CREDIT_W-1:0] - PRICE_C;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rr_ptr_d = rr_ptr_q;
`ifdef VEND_TIMEOUT_EN
    to_cnt_d = '0;
`endif
    case (state_q)
      COLLECT: begin
        if (accept) begin
          rr_ptr_d = nxt_sum[PTR_W-1:0];
          if (credit_sum >= PRICE_W) begin
            credit_d = credit_sub;
            state_d  = DISPENSE;
          end else begin
            credit_d = credit_sum[CREDIT_W-1:0];
          end
        end
`ifdef VEND_TIMEOUT_EN
        // A coin arriving on the expiry cycle takes priority over the refund.
        if (accept || credit_q == '0) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d = '0;
          state_d  = CHANGE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      DISPENSE: begin
        if (bus.dispense_ready) state_d = (credit_q != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        if (credit_q <= CREDIT_W'(1)) begin
          credit_d = '0;
          state_d  = COLLECT;
        end else begin
          credit_d = credit_q - CREDIT_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= COLLECT;
      credit_q         <= '0;
      rr_ptr_q         <= '0;
      dispense_valid_q <= 1'b0;
      change_pulse_q   <= 1'b0;
      busy_q           <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      to_cnt_q         <= '0;
`endif
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      rr_ptr_q         <= rr_ptr_d;
      dispense_valid_q <= (state_d == DISPENSE);
      change_pulse_q   <= (state_d == CHANGE);
      busy_q           <= (state_d != COLLECT);
`ifdef VEND_TIMEOUT_EN
      to_cnt_q         <= to_cnt_d;
`endif
    end
  end

  assign bus.coin_ready     = accept ? (NUM_SLOTS'(1) << gnt_idx) : '0;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.change_pulse   = change_pulse_q;
  assign bus.credit         = credit_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Directed bench for vend_coin_arbiter with PRICE=4, two slots; timeout steps follow VEND_TIMEOUT_EN.
module tb_vend_coin_arbiter;
  localparam int NUM_SLOTS      = 2;
  localparam int PRICE          = 4;
  localparam int CREDIT_W       = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  vend_coin_arbiter_if #(.NUM_SLOTS(NUM_SLOTS), .CREDIT_W(CREDIT_W)) bus ();

  vend_coin_arbiter #(
    .NUM_SLOTS(NUM_SLOTS), .PRICE(PRICE), .CREDIT_W(CREDIT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic coins(input logic [1:0] v, input logic [1:0] val1, input logic [1:0] val0);
    bus.coin_valid = v;
    bus.coin_value = {val1, val0};
    #1;
  endtask

  task automatic handshake();
    bus.dispense_ready = 1'b1;
    cyc();
    bus.dispense_ready = 1'b0;
  endtask

  // Credit can never legally exceed PRICE+2; an underflow wraps above that too.
  always @(negedge clk) begin
    if (reset === 1'b1) chk("credit_bound", 32'(bus.credit <= 4'(PRICE + 2)), 32'd1);
  end

  initial begin
    reset = 1'b0;
    bus.coin_valid = '0;
    bus.coin_value = '0;
    bus.dispense_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_ready", 32'(bus.coin_ready), 0);
    chk("rst_dv", 32'(bus.dispense_valid), 0);
    chk("rst_cp", 32'(bus.change_pulse), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    reset = 1'b1;

    // exact price from slot0, dispenser stalls three cycles
    coins(2'b01, 2'd0, 2'd2);
    chk("t1_ready_a", 32'(bus.coin_ready), 32'b01);
    cyc();
    chk("t1_credit2", 32'(bus.credit), 2);
    chk("t1_busy0", 32'(bus.busy), 0);
    cyc();
    chk("t1_dv", 32'(bus.dispense_valid), 1);
    chk("t1_credit0", 32'(bus.credit), 0);
    chk("t1_ready_busy", 32'(bus.coin_ready), 0);
    coins(2'b00, 2'd0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t1_dv_hold", 32'(bus.dispense_valid), 1);
    end
    handshake();
    chk("t1_dv_done", 32'(bus.dispense_valid), 0);
    chk("t1_busy_done", 32'(bus.busy), 0);
    chk("t1_no_change", 32'(bus.change_pulse), 0);
    chk("t1_credit_end", 32'(bus.credit), 0);

    // overpay 3+3: two change pulses
    coins(2'b01, 2'd0, 2'd3);
    chk("t2_ready_wrap", 32'(bus.coin_ready), 32'b01);
    cyc();
    chk("t2_credit3", 32'(bus.credit), 3);
    coins(2'b10, 2'd3, 2'd0);
    chk("t2_ready_s1", 32'(bus.coin_ready), 32'b10);
    cyc();
    chk("t2_dv", 32'(bus.dispense_valid), 1);
    chk("t2_credit2", 32'(bus.credit), 2);
    coins(2'b00, 2'd0, 2'd0);
    handshake();
    chk("t2_cp1", 32'(bus.change_pulse), 1);
    chk("t2_cp1_credit", 32'(bus.credit), 2);
    chk("t2_cp1_dv", 32'(bus.dispense_valid), 0);
    cyc();
    chk("t2_cp2", 32'(bus.change_pulse), 1);
    chk("t2_cp2_credit", 32'(bus.credit), 1);
    cyc();
    chk("t2_cp_end", 32'(bus.change_pulse), 0);
    chk("t2_credit_end", 32'(bus.credit), 0);
    chk("t2_busy_end", 32'(bus.busy), 0);

    // both slots offering value 1: grants alternate
    coins(2'b11, 2'd1, 2'd1);
    chk("t3_g0", 32'(bus.coin_ready), 32'b01);
    cyc();
    chk("t3_c1", 32'(bus.credit), 1);
    chk("t3_g1", 32'(bus.coin_ready), 32'b10);
    cyc();
    chk("t3_c2", 32'(bus.credit), 2);
    chk("t3_g2", 32'(bus.coin_ready), 32'b01);
    cyc();
    chk("t3_c3", 32'(bus.credit), 3);
    chk("t3_g3", 32'(bus.coin_ready), 32'b10);
    cyc();
    chk("t3_dv", 32'(bus.dispense_valid), 1);
    chk("t3_ready_off", 32'(bus.coin_ready), 0);
    cyc();
    chk("t3_ready_off2", 32'(bus.coin_ready), 0);
    chk("t3_credit0", 32'(bus.credit), 0);
    handshake();
    chk("t3_busy_end", 32'(bus.busy), 0);
    chk("t3_ready_back", 32'(bus.coin_ready), 32'b01);

    // coin held through DISPENSE and CHANGE
    coins(2'b01, 2'd0, 2'd1);
    cyc();
    chk("t4_pre_credit", 32'(bus.credit), 1);
    coins(2'b10, 2'd2, 2'd0);
    cyc();
    chk("t4_credit3", 32'(bus.credit), 3);
    coins(2'b01, 2'd0, 2'd3);
    cyc();
    chk("t4_dv", 32'(bus.dispense_valid), 1);
    chk("t4_credit2", 32'(bus.credit), 2);
    coins(2'b01, 2'd0, 2'd1);
    chk("t4_ready_disp", 32'(bus.coin_ready), 0);
    handshake();
    chk("t4_cp1", 32'(bus.change_pulse), 1);
    chk("t4_ready_chg1", 32'(bus.coin_ready), 0);
    cyc();
    chk("t4_ready_chg2", 32'(bus.coin_ready), 0);
    chk("t4_credit_chg2", 32'(bus.credit), 1);
    cyc();
    chk("t4_busy_end", 32'(bus.busy), 0);
    chk("t4_ready_collect", 32'(bus.coin_ready), 32'b01);
    cyc();
    chk("t4_accepted", 32'(bus.credit), 1);
    coins(2'b00, 2'd0, 2'd0);

    // reset in the middle of CHANGE
    coins(2'b01, 2'd0, 2'd2);
    cyc();
    chk("t5_credit3", 32'(bus.credit), 3);
    coins(2'b10, 2'd3, 2'd0);
    cyc();
    chk("t5_credit2", 32'(bus.credit), 2);
    coins(2'b00, 2'd0, 2'd0);
    handshake();
    chk("t5_cp1", 32'(bus.change_pulse), 1);
    reset = 1'b0;
    cyc();
    chk("t5_credit_rst", 32'(bus.credit), 0);
    chk("t5_cp_rst", 32'(bus.change_pulse), 0);
    chk("t5_busy_rst", 32'(bus.busy), 0);
    chk("t5_dv_rst", 32'(bus.dispense_valid), 0);
    reset = 1'b1;

    // zero-value coin is taken and still moves the pointer
    coins(2'b01, 2'd0, 2'd0);
    chk("z_ready0", 32'(bus.coin_ready), 32'b01);
    cyc();
    chk("z_credit", 32'(bus.credit), 0);
    chk("z_busy", 32'(bus.busy), 0);
    coins(2'b11, 2'd0, 2'd0);
    chk("z_ptr_moved", 32'(bus.coin_ready), 32'b10);
    cyc();
    chk("z_credit2", 32'(bus.credit), 0);
    coins(2'b00, 2'd0, 2'd0);

    // idle with credit outstanding
    coins(2'b01, 2'd0, 2'd3);
    cyc();
    chk("to_credit3", 32'(bus.credit), 3);
    coins(2'b00, 2'd0, 2'd0);
`ifdef VEND_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) cyc();
    chk("to_not_yet", 32'(bus.busy), 0);
    chk("to_not_yet_credit", 32'(bus.credit), 3);
    cyc();
    chk("to_cp1", 32'(bus.change_pulse), 1);
    chk("to_cp1_credit", 32'(bus.credit), 3);
    cyc();
    chk("to_cp2", 32'(bus.change_pulse), 1);
    chk("to_cp2_credit", 32'(bus.credit), 2);
    cyc();
    chk("to_cp3", 32'(bus.change_pulse), 1);
    chk("to_cp3_credit", 32'(bus.credit), 1);
    cyc();
    chk("to_cp_end", 32'(bus.change_pulse), 0);
    chk("to_credit_end", 32'(bus.credit), 0);
    chk("to_busy_end", 32'(bus.busy), 0);
    coins(2'b01, 2'd0, 2'd3);
    cyc();
    chk("tw_credit3", 32'(bus.credit), 3);
    coins(2'b00, 2'd0, 2'd0);
    repeat (TIMEOUT_CYCLES - 1) cyc();
    coins(2'b10, 2'd1, 2'd0);
    chk("tw_ready", 32'(bus.coin_ready), 32'b10);
    cyc();
    coins(2'b00, 2'd0, 2'd0);
    chk("tw_dv", 32'(bus.dispense_valid), 1);
    chk("tw_cp", 32'(bus.change_pulse), 0);
    chk("tw_credit0", 32'(bus.credit), 0);
    handshake();
    chk("tw_busy_end", 32'(bus.busy), 0);
`else
    repeat (20) cyc();
    chk("hold_credit", 32'(bus.credit), 3);
    chk("hold_busy", 32'(bus.busy), 0);
    chk("hold_cp", 32'(bus.change_pulse), 0);
    coins(2'b10, 2'd1, 2'd0);
    chk("hold_ready", 32'(bus.coin_ready), 32'b10);
    cyc();
    coins(2'b00, 2'd0, 2'd0);
    chk("hold_dv", 32'(bus.dispense_valid), 1);
    chk("hold_credit0", 32'(bus.credit), 0);
    handshake();
    chk("hold_busy_end", 32'(bus.busy), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
